// File: rtl/tx_mac_arbiter.sv
// Two-source AXI-Stream frame arbiter feeding a tx MAC: grants whole frames,
// alternates between sources on contention and counts completed frames per source.
module tx_mac_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    input  logic                  s0_axis_tkeep,
    input  logic                  s0_axis_tuser,
    output logic                  s0_axis_trdy,

    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    input  logic                  s1_axis_tkeep,
    input  logic                  s1_axis_tuser,
    output logic                  s1_axis_trdy,

    output logic [DATA_WIDTH-1:0] m_tx_axis_tdata,
    output logic                  m_tx_axis_tvalid,
    output logic                  m_tx_axis_tlast,
    output logic                  m_tx_axis_tkeep,
    output logic                  m_tx_axis_tuser,
    input  logic                  m_tx_axis_trdy,

    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  frame_cnt0,
    output logic [CNT_WIDTH-1:0]  frame_cnt1
);

    // state  | meaning
    // IDLE   | no grant, all outputs quiet; arbitrate pending requests
    // GRANT0 | s0 passed through to the MAC until its tlast beat transfers
    // GRANT1 | s1 passed through to the MAC until its tlast beat transfers
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   frame_end0;
    logic   frame_end1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 2'b00;
        end else begin
            state <= state_next;
            grant <= {state_next == GRANT1, state_next == GRANT0};
            if (state == IDLE && state_next == GRANT0) begin
                last_grant <= 1'b0;
            end else if (state == IDLE && state_next == GRANT1) begin
                last_grant <= 1'b1;
            end
        end
    end

    // A grant is only released by a transferred tlast beat, never by a tvalid gap.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    state_next = last_grant ? GRANT0 : GRANT1;
                end else if (s0_axis_tvalid) begin
                    state_next = GRANT0;
                end else if (s1_axis_tvalid) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                if (frame_end0) begin
                    state_next = IDLE;
                end
            end
            GRANT1: begin
                if (frame_end1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset_n is low so nothing leaks before the reset edge.
    always_comb begin
        m_tx_axis_tdata  = '0;
        m_tx_axis_tvalid = 1'b0;
        m_tx_axis_tlast  = 1'b0;
        m_tx_axis_tkeep  = 1'b0;
        m_tx_axis_tuser  = 1'b0;
        s0_axis_trdy     = 1'b0;
        s1_axis_trdy     = 1'b0;
        if (reset_n) begin
            case (state)
                GRANT0: begin
                    m_tx_axis_tdata  = s0_axis_tdata;
                    m_tx_axis_tvalid = s0_axis_tvalid;
                    m_tx_axis_tlast  = s0_axis_tlast;
                    m_tx_axis_tkeep  = s0_axis_tkeep;
                    m_tx_axis_tuser  = s0_axis_tuser;
                    s0_axis_trdy     = m_tx_axis_trdy;
                end
                GRANT1: begin
                    m_tx_axis_tdata  = s1_axis_tdata;
                    m_tx_axis_tvalid = s1_axis_tvalid;
                    m_tx_axis_tlast  = s1_axis_tlast;
                    m_tx_axis_tkeep  = s1_axis_tkeep;
                    m_tx_axis_tuser  = s1_axis_tuser;
                    s1_axis_trdy     = m_tx_axis_trdy;
                end
                default: ;
            endcase
        end
    end

    assign frame_end0 = (state == GRANT0) && m_tx_axis_tvalid && m_tx_axis_trdy && m_tx_axis_tlast;
    assign frame_end1 = (state == GRANT1) && m_tx_axis_tvalid && m_tx_axis_trdy && m_tx_axis_tlast;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt0 <= '0;
            frame_cnt1 <= '0;
        end else begin
            if (frame_end0) begin
                frame_cnt0 <= frame_cnt0 + CNT_ONE;
            end
            if (frame_end1) begin
                frame_cnt1 <= frame_cnt1 + CNT_ONE;
            end
        end
    end

endmodule
